// File: rtl/sram_arbiter_if.sv
// Request/response and SRAM-command signals of the SRAM arbiter.
// slave = arbiter view, master = requesters plus SRAM controller view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              sram_write;
  logic              sram_read;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_data_write;
  logic [DATA_W-1:0] sram_data_read;
  logic              sram_ready;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, sram_data_read, sram_ready,
    output wr_ready, rd_valid, rd_data, sram_write, sram_read, sram_address, sram_data_write
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, sram_data_read, sram_ready,
    input  wr_ready, rd_valid, rd_data, sram_write, sram_read, sram_address, sram_data_write
  );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates a FIFO-buffered write stream and single outstanding reads onto
// one SRAM controller command port, reads first with a write-fairness escape.
module sram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  sram_arbiter_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rd_overrun
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       STREAK_MAX = 3'd4;

  typedef enum logic [1:0] {IDLE, CMD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full, fifo_empty, push, pop;

  logic              pend_flag, rd_busy, rd_acc, rd_avail;
  logic [ADDR_W-1:0] pend_addr, rd_sel_addr;
  logic              overrun_q;

  logic              op_write, choose_write, start, capture;
  logic [2:0]        streak;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              sram_write_c, sram_read_c;

  // ---------------- write FIFO ----------------
  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = bus.wr_valid && !fifo_full;
  assign pop        = (state == CMD) && op_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  // ---------------- pending read ----------------
  // A read stays outstanding from acceptance until its rd_valid pulse, so a
  // new request in the rd_valid cycle itself is still accepted.
  assign rd_acc      = bus.rd_req && (!rd_busy || rd_valid_q);
  assign rd_avail    = pend_flag || rd_acc;
  assign rd_sel_addr = pend_flag ? pend_addr : bus.rd_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_flag <= 1'b0;
      pend_addr <= '0;
      rd_busy   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (rd_acc) begin
        pend_flag <= 1'b1;
        pend_addr <= bus.rd_addr;
      end else if ((state == CMD) && !op_write) begin
        pend_flag <= 1'b0;
      end
      if (rd_acc)          rd_busy <= 1'b1;
      else if (rd_valid_q) rd_busy <= 1'b0;
      if (bus.rd_req && !rd_acc) overrun_q <= 1'b1;
    end
  end

  // ---------------- arbitration ----------------
  // The IDLE decision also sees a read arriving this cycle, so a request
  // issued on rd_valid is not overtaken by a queued write.
  assign choose_write = !fifo_empty && (!rd_avail || (streak >= STREAK_MAX));
  assign start        = (state == IDLE) && bus.sram_ready && (rd_avail || !fifo_empty);
  assign capture      = (state == WAIT_DONE) && bus.sram_ready && !op_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak   <= '0;
      wait_cnt <= '0;
    end else begin
      if (start) begin
        op_write <= choose_write;
        if (choose_write) begin
          addr_q  <= fifo_addr[rd_ptr];
          wdata_q <= fifo_data[rd_ptr];
          streak  <= '0;
        end else begin
          addr_q <= rd_sel_addr;
          if (!fifo_empty) streak <= streak + 3'd1;
        end
      end
      if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 2'd1;
      else                    wait_cnt <= '0;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = CMD;
      CMD:       state_nx = WAIT_BUSY;
      WAIT_BUSY: if (!bus.sram_ready || (wait_cnt == 2'd3)) state_nx = WAIT_DONE;
      WAIT_DONE: if (bus.sram_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    sram_write_c = 1'b0;
    sram_read_c  = 1'b0;
    if (state == CMD) begin
      sram_write_c = op_write;
      sram_read_c  = !op_write;
    end
  end

  // ---------------- read return ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= capture;
      if (capture) rd_data_q <= bus.sram_data_read;
    end
  end

  assign bus.wr_ready        = !fifo_full;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.sram_write      = sram_write_c;
  assign bus.sram_read       = sram_read_c;
  assign bus.sram_address    = addr_q;
  assign bus.sram_data_write = wdata_q;
  assign fifo_count          = count;
  assign rd_overrun          = overrun_q;
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, write FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid  in  1  draw-side write request; accepted when wr_valid=1 and wr_ready=1.
REQ-007 SHALL have port wr_addr  in  ADDR_W  write address.
REQ-008 SHALL have port wr_data  in  DATA_W  write data.
REQ-009 SHALL have port wr_ready  out  1  FIFO not full.
REQ-010 SHALL have port rd_req  in  1  one-cycle pulse from the display fetcher requesting one read.
REQ-011 SHALL have port rd_addr  in  ADDR_W  read address, sampled with rd_req.
REQ-012 SHALL have port rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port rd_data  out  DATA_W  read result.
REQ-014 SHALL have port fifo_count  out  log2(FIFO_DEPTH)+1  entries held.
REQ-015 SHALL have port rd_overrun  out  1  sticky; rd_req arrived while a read was still pending.
REQ-016 SHALL have ports sram_write, sram_read  out  1 each  one-cycle command pulses to the SRAM controller.
REQ-017 SHALL have ports sram_address  out  ADDR_W  and sram_data_write  out  DATA_W  command operands.
REQ-018 SHALL have ports sram_data_read  in  DATA_W  and sram_ready  in  1  controller result and idle flag.

Function
REQ-019 SHALL be a FIFO_DEPTH-entry FIFO of {addr,data}; push on wr_valid&wr_ready; wr_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
REQ-020 SHALL allow push and pop in the same cycle when not full, leaving count unchanged; a push attempt when full SHALL be ignored even if a pop occurs that cycle.
REQ-021 SHALL latch rd_req into a single pending-read register (addr + flag); rd_req while pending or in flight SHALL be dropped and set rd_overrun until reset.
REQ-022 SHALL use FSM states IDLE, CMD, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE: when sram_ready=1 and work exists, SHALL choose the op and go to CMD; otherwise stay.
REQ-024 Priority SHALL be pending read over FIFO write, except after 4 consecutive reads served while the FIFO was non-empty, one write SHALL be served next; the counter clears on any write.
REQ-025 CMD: exactly one cycle with sram_write or sram_read high, sram_address/sram_data_write driven from the chosen entry; a write pops the FIFO in this cycle; a read clears the pending flag.
REQ-026 sram_address and sram_data_write SHALL hold their CMD values until the next CMD.
REQ-027 WAIT_BUSY: wait for sram_ready=0; if sram_ready is still 1 after 4 cycles, SHALL treat the op as complete and go to WAIT_DONE.
REQ-028 WAIT_DONE: on sram_ready=1 SHALL return to IDLE; for a read, SHALL register sram_data_read into rd_data in that cycle and pulse rd_valid the following cycle.
REQ-029 Minimum spacing between command pulses SHALL be 4 cycles: CMD, WAIT_BUSY, WAIT_DONE, IDLE.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-031 rd_req arriving in the same cycle the previous read's rd_valid pulses SHALL be accepted without overrun.

Reset
REQ-032 On reset=0, SHALL asynchronously force: FSM IDLE, FIFO empty, fifo_count=0, wr_ready=1, pending read clear, fairness counter 0, sram_write=0, sram_read=0, sram_address=0, sram_data_write=0, rd_valid=0, rd_data=0, rd_overrun=0.
REQ-033 Reset mid-operation SHALL abandon any in-flight op with no rd_valid; FIFO contents SHALL be discarded.

Verification
REQ-034 Single write: push addr 0x00010, data 0xAAAA with the controller model idle -> one sram_write pulse with address 0x00010, data 0xAAAA; fifo_count goes 1 then 0.
REQ-035 Read: rd_req with addr 0x00020, model returns 0x0A0A -> one sram_read pulse; rd_valid pulses once with rd_data=0x0A0A.
REQ-036 Fill: push 9 writes while the model holds sram_ready=0 -> wr_ready=0 after the 8th; the 9th is dropped; all 8 are later issued in order.
REQ-037 Priority and fairness: FIFO holds 3 writes, 6 reads are requested back-to-back -> 4 reads, 1 write, 2 reads, then the remaining 2 writes; no rd_overrun.
REQ-038 Overrun: second rd_req while the first is pending -> rd_overrun=1; only one sram_read is issued.
REQ-039 Reset asserted in WAIT_DONE of a read -> no rd_valid; all outputs at reset values; normal operation resumes after release.
